// File: rtl/miriscv_fetch_unit.sv
// Fetch-stage front end: fetch PC, in-flight read tracking with squash of
// stale responses, and a small instruction FIFO presented to decode.
package miriscv_pkg;
  localparam int XLEN = 32;
endpackage

module miriscv_fetch_unit
  import miriscv_pkg::*;
#(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_kill_f_i,
  input  logic            cu_force_f_i,
  input  logic [XLEN-1:0] cu_force_pc_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  output logic            f_valid_o,
  output logic [XLEN-1:0] f_instr_o,
  output logic [XLEN-1:0] f_current_pc_o,
  output logic [XLEN-1:0] f_next_pc_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  deliver_pc;
  logic             started;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] discard;

  logic [XLEN-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] fifo_count;

  logic             flush;
  logic             pop;
  logic             push;
  logic             fifo_empty;
  logic [SUM_W-1:0] occupancy;

  // Requests are throttled so every in-flight read already owns a FIFO slot.
  always_comb begin
    flush          = cu_force_f_i | cu_kill_f_i;
    fifo_empty     = (fifo_count == '0);
    f_valid_o      = ~fifo_empty & ~flush;
    pop            = f_valid_o & ~cu_stall_f_i;
    push           = instr_rvalid_i & (discard == '0) & ~flush;
    occupancy      = SUM_W'(outstanding) + SUM_W'(fifo_count) - SUM_W'(pop);
    instr_req_o    = started & ~flush & (outstanding < MAX_OUT) & (occupancy < DEPTH_S);
    instr_addr_o   = fetch_pc;
    f_instr_o      = fifo_empty ? '0 : fifo_mem[rd_ptr];
    f_current_pc_o = deliver_pc;
    f_next_pc_o    = deliver_pc + PC_STEP;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      fetch_pc    <= '0;
      deliver_pc  <= '0;
      started     <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fifo_count  <= '0;
    end else begin
      if (cu_force_f_i) started <= 1'b1;

      if (instr_rvalid_i && (outstanding == '0))
        outstanding <= '0;
      else
        outstanding <= outstanding + OUT_W'(instr_req_o) - OUT_W'(instr_rvalid_i);

      // Every read still in flight at a flush belongs to the squashed path.
      if (flush)
        discard <= (outstanding == '0) ? '0 : outstanding - OUT_W'(instr_rvalid_i);
      else if (instr_rvalid_i && (discard != '0))
        discard <= discard - OUT_ONE;

      if (cu_force_f_i) begin
        fetch_pc   <= cu_force_pc_i;
        deliver_pc <= cu_force_pc_i;
      end else if (cu_kill_f_i) begin
        fetch_pc   <= deliver_pc;
      end else begin
        if (instr_req_o) fetch_pc   <= fetch_pc + PC_STEP;
        if (pop)         deliver_pc <= deliver_pc + PC_STEP;
      end

      if (flush) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: the storage array is deliberately not reset; validity lives in the
  // reset pointers/count, and f_instr_o is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= instr_rdata_i;
  end

  rvalid_tracked: assert property (@(posedge clk_i) disable iff (!arstn_i)
    instr_rvalid_i |-> (outstanding != '0));

endmodule
